// File: rtl/sound_recorder_if.sv
// Sound recorder bus: control/ADC inputs, SRAM controls and status outputs.
// Latency: n/a (signal bundle only). Backpressure: none; ADC strobes are fire-and-forget.
// Optional peak_level signal present when SOUND_REC_PEAK_EN is defined.
interface sound_recorder_if #(
    parameter int ADDR_W = 20
);
    logic              Run;
    logic [15:0]       adc_data;
    logic              adc_valid;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic              Busy;
    logic              Done;
    logic              Overflow;
    logic [ADDR_W-1:0] rec_count;
`ifdef SOUND_REC_PEAK_EN
    logic [15:0]       peak_level;
`endif

    // Stimulus side (audio front end / testbench)
    modport master (
        output Run, adc_data, adc_valid,
        input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        input  Busy, Done, Overflow, rec_count
`ifdef SOUND_REC_PEAK_EN
        , input peak_level
`endif
    );

    // Recorder side
    modport slave (
        input  Run, adc_data, adc_valid,
        output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        output Busy, Done, Overflow, rec_count
`ifdef SOUND_REC_PEAK_EN
        , output peak_level
`endif
    );
endinterface

// File: rtl/sound_recorder.sv
// Records 16-bit ADC samples into sequential SRAM words from address 0 up to MAX_ADDR.
// Latency: push-to-SETUP >= 1 clk; each SRAM write takes WE_CYCLES+2 clks (SETUP, WRITE x N, HOLD).
// Backpressure: none upstream; samples arriving on a full FIFO are dropped and flag Overflow. Optional SOUND_REC_PEAK_EN adds peak_level.
module sound_recorder #(
    parameter int              ADDR_W     = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(20'h948B9),
    parameter int              FIFO_DEPTH = 4,
    parameter int              WE_CYCLES  = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    inout  wire  [15:0]       SRAM_DQ,
    sound_recorder_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int WCW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [15:0]       fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q, rec_count_q;
    logic [WCW-1:0]    we_cnt_q;
    logic              overflow_q;
    logic              ce_n_q, we_n_q, dq_oe_q, busy_q, done_q;

    logic              in_capture, push_req, push_ok, pop, fifo_full, fifo_empty, arm;

    // Push/pop qualification and next-state decode; full is judged before any same-cycle pop
    always_comb begin
        in_capture = (state_q == S_REC) || (state_q == S_SETUP) ||
                     (state_q == S_WRITE) || (state_q == S_HOLD);
        push_req   = bus.adc_valid && bus.Run && in_capture;
        fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
        fifo_empty = (cnt_q == '0);
        push_ok    = push_req && !fifo_full;
        arm        = (state_q == S_IDLE) && bus.Run;
        pop        = 1'b0;
        state_d    = state_q;
        case (state_q)
            S_IDLE:  if (bus.Run) state_d = S_REC;
            S_REC: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end else if (!bus.Run) begin
                    state_d = S_DRAIN;
                end
            end
            S_SETUP: state_d = S_WRITE;
            S_WRITE: if (we_cnt_q == '0) state_d = S_HOLD;
            S_HOLD: begin
                if (addr_q == MAX_ADDR) begin
                    state_d = S_DONE;
                end else if (bus.Run) begin
                    // Go straight to the next write when data is waiting: back-to-back cycles
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_REC;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  if (!bus.Run) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with SRAM strobes and status registered from the next state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ce_n_q  <= !(state_d inside {S_SETUP, S_WRITE, S_HOLD});
            dq_oe_q <=  (state_d inside {S_SETUP, S_WRITE, S_HOLD});
            we_n_q  <= (state_d != S_WRITE);
            busy_q  <=  (state_d inside {S_REC, S_SETUP, S_WRITE, S_HOLD, S_DRAIN});
            done_q  <= (state_d == S_DONE);
        end
    end

    // Sample FIFO storage; no reset needed since pointers gate validity
    always_ff @(posedge Clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= bus.adc_data;
    end

    // FIFO pointers, write register, address/count tracking and overflow flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            rec_count_q <= '0;
            we_cnt_q    <= '0;
            overflow_q  <= 1'b0;
        end else if (arm) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            rec_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                wdata_q  <= fifo_q[rd_ptr_q];
            end
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
            if (push_req && fifo_full) overflow_q <= 1'b1;
            if (state_q == S_SETUP) begin
                we_cnt_q <= WCW'(WE_CYCLES - 1);
            end else if ((state_q == S_WRITE) && (we_cnt_q != '0)) begin
                we_cnt_q <= we_cnt_q - WCW'(1);
            end
            // Word committed at end of HOLD; the address parks at MAX_ADDR rather than wrapping
            if (state_q == S_HOLD) begin
                rec_count_q <= rec_count_q + ADDR_W'(1);
                if (addr_q != MAX_ADDR) addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

`ifdef SOUND_REC_PEAK_EN
    logic [15:0] peak_q;
    logic [15:0] mag;

    // Magnitude of the incoming sample; 0x8000 saturates to 0x7FFF
    always_comb begin
        mag = bus.adc_data;
        if (bus.adc_data[15]) begin
            mag = (bus.adc_data == 16'h8000) ? 16'h7FFF : (~bus.adc_data + 16'd1);
        end
    end

    // Track the largest magnitude among accepted samples of this recording
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            peak_q <= '0;
        end else if (arm) begin
            peak_q <= '0;
        end else if (push_ok && (mag > peak_q)) begin
            peak_q <= mag;
        end
    end

    assign bus.peak_level = peak_q;
`endif

    assign SRAM_DQ       = dq_oe_q ? wdata_q : 16'hzzzz;
    assign bus.SRAM_ADDR = addr_q;
    assign bus.SRAM_CE_N = ce_n_q;
    assign bus.SRAM_OE_N = 1'b1;
    assign bus.SRAM_WE_N = we_n_q;
    assign bus.SRAM_UB_N = 1'b0;
    assign bus.SRAM_LB_N = 1'b0;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Overflow  = overflow_q;
    assign bus.rec_count = rec_count_q;

endmodule

// File: tb/tb_sound_recorder.sv
// Directed bench for sound_recorder (MAX_ADDR overridden to 5) with a behavioural SRAM capture monitor.
module tb_sound_recorder;
    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    wire [15:0] sram_dq;

    sound_recorder_if ifc ();

    sound_recorder #(.MAX_ADDR(20'd5)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .SRAM_DQ (sram_dq),
        .bus     (ifc.slave)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // SRAM model: a write lands when WE_N returns high with DQ still driven
    int          cyc = 0, pulses = 0, last_w = 0, cur_w = 0, last_gap = 0, start_cyc = 0, oe_bad = 0;
    logic [15:0] mem [16];

    always @(posedge Clk) begin
        cyc++;
        if (ifc.SRAM_OE_N !== 1'b1) oe_bad++;
        if (Reset) begin
            cur_w = 0;
        end else if (ifc.SRAM_WE_N === 1'b0) begin
            if (cur_w == 0) begin
                last_gap  = cyc - start_cyc;
                start_cyc = cyc;
            end
            cur_w++;
        end else if (cur_w != 0) begin
            last_w = cur_w;
            cur_w  = 0;
            pulses++;
            if (ifc.SRAM_ADDR < 20'd16) mem[ifc.SRAM_ADDR[3:0]] = sram_dq;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [15:0] d);
        ifc.adc_data  = d;
        ifc.adc_valid = 1'b1;
        tick();
        ifc.adc_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (ifc.Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int p0;
        ifc.Run       = 1'b0;
        ifc.adc_data  = 16'h0;
        ifc.adc_valid = 1'b0;

        // Reset state
        tick(2);
        check("rst_addr",  32'(ifc.SRAM_ADDR), 32'h0);
        check("rst_count", 32'(ifc.rec_count), 32'h0);
        check("rst_busy",  32'(ifc.Busy), 32'h0);
        check("rst_done",  32'(ifc.Done), 32'h0);
        check("rst_ovf",   32'(ifc.Overflow), 32'h0);
        check("rst_ce",    32'(ifc.SRAM_CE_N), 32'h1);
        check("rst_oe",    32'(ifc.SRAM_OE_N), 32'h1);
        check("rst_we",    32'(ifc.SRAM_WE_N), 32'h1);
        check("rst_ublb",  32'({ifc.SRAM_UB_N, ifc.SRAM_LB_N}), 32'h0);
        Reset = 1'b0;
        tick();

        // Two samples 1134 clocks apart
        ifc.Run = 1'b1;
        tick();
        check("t1_busy", 32'(ifc.Busy), 32'h1);
        strobe(16'h1234);
        tick(1133);
        strobe(16'h5678);
        tick(20);
        check("t1_mem0",   32'(mem[0]), 32'h1234);
        check("t1_mem1",   32'(mem[1]), 32'h5678);
        check("t1_wewid",  32'(last_w), 32'd2);
        check("t1_pulses", 32'(pulses), 32'd2);
        check("t1_count",  32'(ifc.rec_count), 32'd2);
        check("t1_addr",   32'(ifc.SRAM_ADDR), 32'd2);
        check("t1_ovf",    32'(ifc.Overflow), 32'h0);
        ifc.Run = 1'b0;
        wait_done(10, ok);
        check("t1_done_seen", 32'(ok), 32'h1);
        check("t1_done_cnt",  32'(ifc.rec_count), 32'd2);
        tick();
        check("t1_idle_done", 32'(ifc.Done), 32'h0);
        check("t1_idle_busy", 32'(ifc.Busy), 32'h0);

        // Six consecutive strobes into a 4-deep FIFO
        ifc.Run = 1'b1;
        tick();
        check("t2_cnt_clr",  32'(ifc.rec_count), 32'h0);
        check("t2_addr_clr", 32'(ifc.SRAM_ADDR), 32'h0);
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            ifc.adc_data  = 16'hA000 + 16'(i);
            ifc.adc_valid = 1'b1;
            tick();
        end
        ifc.adc_valid = 1'b0;
        check("t2_ovf", 32'(ifc.Overflow), 32'h1);
        tick(30);
        check("t2_writes", 32'(pulses - p0), 32'd5);
        check("t2_mem0",   32'(mem[0]), 32'hA000);
        check("t2_mem4",   32'(mem[4]), 32'hA004);
        check("t2_gap",    32'(last_gap), 32'd4);
        check("t2_count",  32'(ifc.rec_count), 32'd5);
        ifc.Run = 1'b0;
        wait_done(20, ok);
        check("t2_done_seen", 32'(ok), 32'h1);
        tick(2);

        // Continuous samples reach MAX_ADDR=5
        ifc.Run = 1'b1;
        tick();
        check("t3_ovf_clr", 32'(ifc.Overflow), 32'h0);
        p0 = pulses;
        ifc.adc_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ifc.adc_data = 16'hB000 + 16'(i);
            tick();
        end
        ifc.adc_valid = 1'b0;
        tick(5);
        check("t3_done",   32'(ifc.Done), 32'h1);
        check("t3_busy",   32'(ifc.Busy), 32'h0);
        check("t3_count",  32'(ifc.rec_count), 32'd6);
        check("t3_writes", 32'(pulses - p0), 32'd6);
        check("t3_mem0",   32'(mem[0]), 32'hB000);
        check("t3_mem1",   32'(mem[1]), 32'hB001);
        tick(20);
        check("t3_no7th",   32'(pulses - p0), 32'd6);
        check("t3_done_hd", 32'(ifc.Done), 32'h1);
        ifc.Run = 1'b0;
        tick(2);
        check("t3_idle", 32'(ifc.Done), 32'h0);

        // Run drops mid-write with three samples queued
        ifc.Run = 1'b1;
        tick();
        p0 = pulses;
        for (int i = 0; i < 4; i++) strobe(16'hC000 + 16'(i));
        ifc.Run = 1'b0;
        strobe(16'hC0FF);
        wait_done(60, ok);
        check("t4_done_seen", 32'(ok), 32'h1);
        check("t4_count",     32'(ifc.rec_count), 32'd4);
        check("t4_writes",    32'(pulses - p0), 32'd4);
        check("t4_mem0",      32'(mem[0]), 32'hC000);
        check("t4_mem3",      32'(mem[3]), 32'hC003);
        tick(10);
        check("t4_ignored",   32'(pulses - p0), 32'd4);

        // Reset asserted during the second write
        ifc.Run = 1'b1;
        tick();
        strobe(16'hD000);
        strobe(16'hD001);
        tick(5);
        check("t5_we_low",  32'(ifc.SRAM_WE_N), 32'h0);
        check("t5_count1",  32'(ifc.rec_count), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("t5_we_abort", 32'(ifc.SRAM_WE_N), 32'h1);
        check("t5_ce_abort", 32'(ifc.SRAM_CE_N), 32'h1);
        check("t5_count0",   32'(ifc.rec_count), 32'h0);
        check("t5_busy0",    32'(ifc.Busy), 32'h0);
        tick(2);
        Reset = 1'b0;
        tick();
        p0 = pulses;
        strobe(16'hE000);
        tick(10);
        check("t5_restart_mem", 32'(mem[0]), 32'hE000);
        check("t5_restart_wr",  32'(pulses - p0), 32'd1);
        check("t5_restart_adr", 32'(ifc.SRAM_ADDR), 32'd1);

`ifdef SOUND_REC_PEAK_EN
        // Peak magnitude tracking
        ifc.Run = 1'b0;
        tick(5);
        ifc.Run = 1'b1;
        tick();
        check("pk_clear", 32'(ifc.peak_level), 32'h0);
        strobe(16'h0100);
        tick(6);
        check("pk_0100", 32'(ifc.peak_level), 32'h0100);
        strobe(16'hFF00);
        tick(6);
        check("pk_ff00", 32'(ifc.peak_level), 32'h0100);
        strobe(16'h8000);
        tick(6);
        check("pk_8000", 32'(ifc.peak_level), 32'h7FFF);
        ifc.Run = 1'b0;
        tick(10);
        check("pk_held", 32'(ifc.peak_level), 32'h7FFF);
        ifc.Run = 1'b1;
        tick();
        check("pk_rearm", 32'(ifc.peak_level), 32'h0);
`endif

        check("oe_never_low", 32'(oe_bad), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
